// File: rtl/jk_counter_ctrl.sv
// Sequencing controller for a bank of JK flip-flops acting as an up/down counter.
// Optional sticky wrap flag enabled by defining JK_CNT_OVF_EN.
module jk_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             start_i,
    input  logic             up_dn_i,
    input  logic             pause_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] term_i,
    output logic [WIDTH-1:0] j_vec_o,
    output logic [WIDTH-1:0] k_vec_o,
    output logic [WIDTH-1:0] q_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] j_d, k_d;
    logic [WIDTH-1:0] tog_up, tog_dn;

    // Carry/borrow chain: a bit toggles when every lower bit is 1 (up) or 0 (down).
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tog
            if (gi == 0) begin : g_lsb
                assign tog_up[gi] = 1'b1;
                assign tog_dn[gi] = 1'b1;
            end else begin : g_upper
                assign tog_up[gi] = &q_q[gi-1:0];
                assign tog_dn[gi] = ~|q_q[gi-1:0];
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        j_d     = '0;
        k_d     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (ld_i) begin
                    j_d = d_i;
                    k_d = ~d_i;
                end
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (pause_i) begin
                    state_d = S_RUN;
                end else if (q_q == term_i) begin
                    state_d = S_FINISH;
                end else begin
                    j_d = up_dn_i ? tog_up : tog_dn;
                    k_d = up_dn_i ? tog_up : tog_dn;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Standard JK bank update: 00 hold, 01 reset, 10 set, 11 toggle.
    assign q_d = (j_d & ~q_q) | (~k_d & q_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
        end
    end

    // Commands are forced quiet while reset is held, even if LD is high.
    assign j_vec_o = {WIDTH{rst_n_i}} & j_d;
    assign k_vec_o = {WIDTH{rst_n_i}} & k_d;
    assign q_o     = q_q;
    assign busy_o  = (state_q == S_RUN);
    assign done_o  = (state_q == S_FINISH);

`ifdef JK_CNT_OVF_EN
    logic ovf_q;
    logic wrap;

    // Bit 0 toggling is only possible on a counting cycle.
    assign wrap = j_d[0] & k_d[0] & (up_dn_i ? (&q_q) : (~|q_q));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start_i) begin
            ovf_q <= 1'b0;
        end else if (wrap) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Randomized scoreboard bench for jk_counter_ctrl (WIDTH=4) with a behavioural counter model.
module tb_jk_counter_ctrl;

    localparam int W = 4;
    localparam int M = 16;

    logic         clk;
    logic         rst_n;
    logic         ld;
    logic [W-1:0] d;
    logic         start;
    logic         up_dn;
    logic         pause;
    logic         abort;
    logic [W-1:0] term;
    logic [W-1:0] j_vec;
    logic [W-1:0] k_vec;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int j;
        int k;
        int q;
        int busy;
        int done;
        int ovf;
    } exp_t;

    exp_t sb[$];

    // Model: phase 0 = idle, 1 = running, 2 = finishing
    int m_phase = 0;
    int m_q     = 0;
    int m_ovf   = 0;

    jk_counter_ctrl #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .ld_i    (ld),
        .d_i     (d),
        .start_i (start),
        .up_dn_i (up_dn),
        .pause_i (pause),
        .abort_i (abort),
        .term_i  (term),
        .j_vec_o (j_vec),
        .k_vec_o (k_vec),
        .q_o     (q),
        .busy_o  (busy),
        .done_o  (done),
        .ovf_o   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model predicts this cycle's J/K and the post-edge state.
    task automatic cycle(input int i_ld, input int i_d, input int i_start, input int i_up,
                         input int i_pause, input int i_abort, input int i_term);
        exp_t e;
        int   nxt;
        @(negedge clk);
        ld    = i_ld[0];
        d     = i_d[W-1:0];
        start = i_start[0];
        up_dn = i_up[0];
        pause = i_pause[0];
        abort = i_abort[0];
        term  = i_term[W-1:0];
        e.j = 0;
        e.k = 0;
        if (m_phase == 0) begin
            if (i_ld != 0) begin
                e.j = i_d;
                e.k = (~i_d) & (M - 1);
                m_q = i_d;
            end
            if (i_start != 0) begin
                m_phase = 1;
                m_ovf   = 0;
            end
        end else if (m_phase == 1) begin
            if (i_abort != 0)       m_phase = 0;
            else if (i_pause != 0)  m_phase = 1;
            else if (m_q == i_term) m_phase = 2;
            else begin
                nxt = (i_up != 0) ? (m_q + 1) % M : (m_q + M - 1) % M;
                e.j = m_q ^ nxt;
                e.k = m_q ^ nxt;
                if ((i_up != 0 && nxt == 0) || (i_up == 0 && nxt == M - 1)) m_ovf = 1;
                m_q = nxt;
            end
        end else begin
            m_phase = 0;
        end
        e.q    = m_q;
        e.busy = (m_phase == 1) ? 1 : 0;
        e.done = (m_phase == 2) ? 1 : 0;
`ifdef JK_CNT_OVF_EN
        e.ovf = m_ovf;
`else
        e.ovf = 0;
`endif
        sb.push_back(e);
    endtask

    // Monitor: J/K checked mid-low-phase, registered outputs checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("j_vec", int'(j_vec), e.j);
                chk("k_vec", int'(k_vec), e.k);
                @(posedge clk);
                #1;
                chk("q", int'(q), e.q);
                chk("busy", int'(busy), e.busy);
                chk("done", int'(done), e.done);
                chk("ovf", int'(ovf), e.ovf);
                $display("txn: q=%0d busy=%0d done=%0d ovf=%0d", q, busy, done, ovf);
            end
        end
    end

    initial begin
        int r_term;
        rst_n = 1'b0;
        ld = 1'b1; d = 4'h9; start = 1'b0; up_dn = 1'b0;
        pause = 1'b0; abort = 1'b0; term = '0;
        #22;
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_j", int'(j_vec), 0);
        chk("rst_k", int'(k_vec), 0);
        ld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Load 9
        cycle(1, 9, 0, 0, 0, 0, 0);
        // Count up 2 -> 5
        cycle(1, 2, 1, 1, 0, 0, 5);
        repeat (5) cycle(0, 0, 0, 1, 0, 0, 5);
        // Wrap down 1 -> 0 -> 15 -> 14
        cycle(1, 1, 1, 0, 0, 0, 14);
        repeat (5) cycle(0, 0, 0, 0, 0, 0, 14);
        // Pause at 6 for three cycles, then abort
        cycle(1, 4, 1, 1, 0, 0, 12);
        repeat (2) cycle(0, 0, 0, 1, 0, 0, 12);
        repeat (3) cycle(0, 0, 0, 1, 1, 0, 12);
        cycle(0, 0, 0, 1, 0, 1, 12);
        cycle(0, 0, 0, 1, 0, 0, 12);
        // Immediate terminal
        cycle(1, 7, 1, 1, 0, 0, 7);
        repeat (3) cycle(0, 0, 0, 1, 0, 0, 7);

        // Randomized traffic
        r_term = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) r_term = int'($urandom_range(0, M - 1));
            cycle(($urandom_range(0, 9) == 0) ? 1 : 0,
                  int'($urandom_range(0, M - 1)),
                  ($urandom_range(0, 4) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  ($urandom_range(0, 6) == 0) ? 1 : 0,
                  ($urandom_range(0, 24) == 0) ? 1 : 0,
                  r_term);
        end

        // Asynchronous reset mid-run with Q=3
        cycle(0, 0, 0, 1, 0, 1, 10);
        cycle(0, 0, 0, 1, 0, 0, 10);
        cycle(1, 3, 1, 1, 0, 0, 10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_q", int'(q), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_ovf", int'(ovf), 0);
        chk("arst_j", int'(j_vec), 0);
        m_phase = 0;
        m_q     = 0;
        m_ovf   = 0;
        ld = 1'b0; start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 1, 1, 0, 0, 2);
        repeat (4) cycle(0, 0, 0, 1, 0, 0, 2);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        #3;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_counter_ctrl.md
Name: jk_counter_ctrl

Overview:
- Sequencing controller for a WIDTH-bit bank of JK flip-flops wired as a synchronous up/down counter.
- Each cycle, the controller generates per-bit J/K commands (hold, set, reset, toggle) from an FSM driven by START/ABORT/PAUSE.
- The JK bank is modelled inside the block with standard JK semantics: 00 hold, 01 reset, 10 set, 11 toggle.
- Sits between a simple host (push-buttons or testbench) and the JK register; reports BUSY/DONE.

Parameters:
- WIDTH, 4, number of JK flip-flops / counter bits (2..16).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- LD  input  1  load request; honoured only in IDLE.
- D  input  WIDTH  load value.
- START  input  1  start request; honoured only in IDLE.
- UP_DN  input  1  1 = count up, 0 = count down; sampled every RUN cycle.
- PAUSE  input  1  hold counter while in RUN.
- ABORT  input  1  terminate run, return to IDLE.
- TERM  input  WIDTH  terminal count value.
- J_VEC  output  WIDTH  J commands applied to bank this cycle (combinational).
- K_VEC  output  WIDTH  K commands applied to bank this cycle (combinational).
- Q  output  WIDTH  JK bank state.
- BUSY  output  1  high in RUN.
- DONE  output  1  one-cycle pulse in FINISH.
- OVF  output  1  sticky wrap flag (see Optional Feature).

Behaviour:
- Reset (RST_N=0, asynchronous): Q=0, state=IDLE, BUSY=0, DONE=0, OVF=0. J_VEC/K_VEC=0 while in reset.
- States: IDLE, RUN, FINISH. Registered outputs are BUSY=(state==RUN) and DONE=(state==FINISH).
- IDLE:
  - LD=1: J=D, K=~D, so Q=D after the edge.
  - LD=0: J=K=0, Q holds.
  - START=1: next state is RUN. If LD and START are both high, the load and the transition to RUN happen on the same edge.
  - PAUSE, ABORT and UP_DN are ignored.
- RUN, priority ABORT > PAUSE > terminal > count:
  - ABORT=1: J=K=0, next state IDLE, Q retained, no DONE.
  - PAUSE=1: J=K=0, remain in RUN.
  - Q==TERM: J=K=0, next state FINISH.
  - Otherwise count:
    - Up: bit i toggles (J_i=K_i=1) iff Q[i-1:0] are all 1; bit 0 always toggles.
    - Down: bit i toggles iff Q[i-1:0] are all 0.
    - Non-toggling bits get J=K=0.
- FINISH: J=K=0; DONE=1 for exactly one cycle; unconditional return to IDLE. START in FINISH is ignored.
- Latency:
  - START sampled at edge n gives BUSY=1 after edge n.
  - First count occurs at edge n+1.
  - If Q==TERM on RUN entry, the block reaches FINISH after one cycle with zero counts.
  - With no pause, N counts to TERM take N+1 RUN cycles, then 1 FINISH cycle.
- Wrap: arithmetic is modulo 2^WIDTH. Up from all-ones gives 0; down from 0 gives all-ones. Counting continues until Q==TERM.
- UP_DN may change mid-run; it takes effect on the next counting cycle.
- Reset asserted mid-RUN aborts immediately: Q=0, IDLE, no DONE.
- Outputs never contain X after reset.

Optional Feature:
- Macro: JK_CNT_OVF_EN.
- Defined:
  - OVF is set on any counting edge where Q wraps (all-ones to 0 up, or 0 to all-ones down).
  - OVF stays set until cleared by START accepted in IDLE or by reset.
  - If a START in IDLE clears OVF, no wrap can occur on that same edge.
- Undefined: OVF tied to 0; no extra flops.

Test Plan (WIDTH=4):
- Reset/load: RST_N=0 then release, LD=1, D=4'h9 in IDLE → Q=0 during reset; Q=9 after one edge; BUSY=0, DONE=0.
- Count up: Q=2, TERM=5, UP_DN=1, START pulse → BUSY high 4 cycles, Q sequence 3,4,5 → DONE single pulse, Q=5, back to IDLE.
- Wrap down: Q=1, TERM=14, UP_DN=0, START → Q goes 0, 15, 14; DONE pulse. With JK_CNT_OVF_EN, OVF=1 from the 0→15 edge; without it, OVF=0.
- Pause/abort: during a run with Q=6, assert PAUSE 3 cycles → Q stays 6, J_VEC=K_VEC=0. Then ABORT → IDLE next edge, Q retained, no DONE.
- Immediate terminal: Q=7, TERM=7, START → one RUN cycle, no count, DONE pulse, Q=7.
- Async reset mid-run: drop RST_N between edges while Q=3 in RUN → Q=0, BUSY=0 immediately, without waiting for a clock edge.
